// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write path.
// Used by the write arbiter and its holding buffers.
package regfile_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int REG_COUNT = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } writeReq_t;

  function automatic logic [REG_COUNT-1:0] regOneHot(
    input logic [ADDR_W-1:0] r
  );
    logic [REG_COUNT-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/write_req_buffer.sv
// One-entry holding buffer between a requester and the arbiter.
// A load in the same cycle as a drain keeps the buffer full.
module write_req_buffer
  import regfile_pkg::*;
(
  input  logic      clock,
  input  logic      resetN,
  input  logic      flush,
  input  logic      load,
  input  logic      drain,
  input  writeReq_t dataLoad,
  output logic      valid,
  output writeReq_t entry
);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      valid <= 1'b0;
      entry <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (load)
        valid <= 1'b1;
      else if (drain)
        valid <= 1'b0;
      if (load && !flush)
        entry <= dataLoad;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-port round-robin arbiter for the single regFile write port.
// Same-destination writes commit in acceptance order via the age bit.
module regfile_write_arbiter
  import regfile_pkg::writeReq_t,
         regfile_pkg::REG_COUNT,
         regfile_pkg::regOneHot;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 flush,
  input  logic                 req0Valid,
  input  logic [ADDR_W-1:0]    req0Reg,
  input  logic [DATA_W-1:0]    req0Data,
  input  logic                 req1Valid,
  input  logic [ADDR_W-1:0]    req1Reg,
  input  logic [DATA_W-1:0]    req1Data,
  output logic                 req0Ready,
  output logic                 req1Ready,
  output logic                 enableWrite,
  output logic [ADDR_W-1:0]    registerWrite,
  output logic [DATA_W-1:0]    dataIn,
  output logic [REG_COUNT-1:0] pendingMask
);

  writeReq_t in0, in1, buf0, buf1, outReq;
  logic      bufValid0, bufValid1;
  logic      grant0Raw, grant1Raw;
  logic      grant0, grant1;
  logic      acc0, acc1;
  logic      sameDest, contended;
  logic      rrPtr, older, outValid;

  assign in0 = '{dest: req0Reg, data: req0Data};
  assign in1 = '{dest: req1Reg, data: req1Data};

  assign sameDest  = buf0.dest == buf1.dest;
  assign contended = bufValid0 && bufValid1 && !sameDest;

  always_comb begin
    grant0Raw = 1'b0;
    grant1Raw = 1'b0;
    unique case (1'b1)
      (bufValid0 && !bufValid1): grant0Raw = 1'b1;
      (!bufValid0 && bufValid1): grant1Raw = 1'b1;
      (bufValid0 && bufValid1 && sameDest): begin
        grant0Raw = !older;
        grant1Raw = older;
      end
      contended: begin
        grant0Raw = !rrPtr;
        grant1Raw = rrPtr;
      end
      default: ;
    endcase
  end

  // Ready uses the unsuppressed grant so it never looks at flush.
  assign grant0    = grant0Raw && !flush;
  assign grant1    = grant1Raw && !flush;
  assign req0Ready = !bufValid0 || grant0Raw;
  assign req1Ready = !bufValid1 || grant1Raw;
  assign acc0      = req0Valid && req0Ready && !flush;
  assign acc1      = req1Valid && req1Ready && !flush;

  write_req_buffer u_buf0 (
    .clock    (clock),
    .resetN   (resetN),
    .flush    (flush),
    .load     (acc0),
    .drain    (grant0),
    .dataLoad (in0),
    .valid    (bufValid0),
    .entry    (buf0)
  );

  write_req_buffer u_buf1 (
    .clock    (clock),
    .resetN   (resetN),
    .flush    (flush),
    .load     (acc1),
    .drain    (grant1),
    .dataLoad (in1),
    .valid    (bufValid1),
    .entry    (buf1)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rrPtr    <= 1'b0;
      older    <= 1'b0;
      outValid <= 1'b0;
      outReq   <= '0;
    end else begin
      if (flush)
        older <= 1'b0;
      else if (acc0 && acc1)
        older <= 1'b0;
      else if (acc0 && bufValid1 && !grant1)
        older <= 1'b1;
      else if (acc1 && bufValid0 && !grant0)
        older <= 1'b0;
      if (contended && !flush)
        rrPtr <= !rrPtr;
      outValid <= grant0 || grant1;
      if (grant0)
        outReq <= buf0;
      else if (grant1)
        outReq <= buf1;
      else
        outReq <= '0;
    end
  end

  assign enableWrite   = outValid && (outReq.dest != '0);
  assign registerWrite = outReq.dest;
  assign dataIn        = outReq.data;

  always_comb begin
    pendingMask = '0;
    if (bufValid0)
      pendingMask = pendingMask | regOneHot(buf0.dest);
    if (bufValid1)
      pendingMask = pendingMask | regOneHot(buf1.dest);
    if (outValid)
      pendingMask = pendingMask | regOneHot(outReq.dest);
    pendingMask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table plus
// scoreboarded sequences for ordering, r0, flush and reset.
module tb_regfile_write_arbiter;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       flush = 1'b0;
  logic       req0Valid = 1'b0;
  logic [2:0] req0Reg = '0;
  logic [7:0] req0Data = '0;
  logic       req1Valid = 1'b0;
  logic [2:0] req1Reg = '0;
  logic [7:0] req1Data = '0;
  logic       req0Ready, req1Ready;
  logic       enableWrite;
  logic [2:0] registerWrite;
  logic [7:0] dataIn;
  logic [7:0] pendingMask;

  int checks = 0;
  int errors = 0;
  logic sbOn = 1'b0;
  logic [10:0] expQ[$];

  regfile_write_arbiter dut (
    .clock         (clock),
    .resetN        (resetN),
    .flush         (flush),
    .req0Valid     (req0Valid),
    .req0Reg       (req0Reg),
    .req0Data      (req0Data),
    .req1Valid     (req1Valid),
    .req1Reg       (req1Reg),
    .req1Data      (req1Data),
    .req0Ready     (req0Ready),
    .req1Ready     (req1Ready),
    .enableWrite   (enableWrite),
    .registerWrite (registerWrite),
    .dataIn        (dataIn),
    .pendingMask   (pendingMask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v0;
    logic [2:0] r0;
    logic [7:0] d0;
    logic       v1;
    logic [2:0] r1;
    logic [7:0] d1;
    logic       eRdy0;
    logic       eRdy1;
    logic       eEn;
    logic [2:0] eReg;
    logic [7:0] eData;
    logic [7:0] eMask;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(
    input logic v0, input logic [2:0] r0,
    input logic [7:0] d0,
    input logic v1, input logic [2:0] r1,
    input logic [7:0] d1,
    input logic rd0, input logic rd1,
    input logic en, input logic [2:0] rg,
    input logic [7:0] dt, input logic [7:0] mk8
  );
    vec_t v;
    v.v0 = v0; v.r0 = r0; v.d0 = d0;
    v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.eRdy0 = rd0; v.eRdy1 = rd1;
    v.eEn = en; v.eReg = rg;
    v.eData = dt; v.eMask = mk8;
    return v;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic step(
    input logic v0, input logic [2:0] r0,
    input logic [7:0] d0,
    input logic v1, input logic [2:0] r1,
    input logic [7:0] d1,
    input logic fl
  );
    @(negedge clock);
    req0Valid = v0; req0Reg = r0; req0Data = d0;
    req1Valid = v1; req1Reg = r1; req1Data = d1;
    flush = fl;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(
    input logic [2:0] r, input logic [7:0] d
  );
    expQ.push_back({r, d});
  endtask

  task automatic drained(input string name);
    chk(name, expQ.size(), 0);
    expQ.delete();
  endtask

  always @(negedge clock) begin
    if (sbOn && resetN && enableWrite) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got r%0d=%0h want none",
                 registerWrite, dataIn);
      end else begin
        chk("sb_write", {registerWrite, dataIn},
            expQ.pop_front());
      end
    end
  end

  initial begin
    vecs[0]  = mk(1,3,8'h5A, 0,0,0,     1,1, 0,0,0,     8'h00);
    vecs[1]  = mk(0,0,0,     0,0,0,     1,1, 0,0,0,     8'h08);
    vecs[2]  = mk(0,0,0,     0,0,0,     1,1, 1,3,8'h5A, 8'h08);
    vecs[3]  = mk(0,0,0,     0,0,0,     1,1, 0,0,0,     8'h00);
    vecs[4]  = mk(1,1,8'h11, 1,2,8'h22, 1,1, 0,0,0,     8'h00);
    vecs[5]  = mk(1,1,8'h11, 1,2,8'h22, 1,0, 0,0,0,     8'h06);
    vecs[6]  = mk(1,1,8'h11, 1,2,8'h22, 0,1, 1,1,8'h11, 8'h06);
    vecs[7]  = mk(1,1,8'h11, 1,2,8'h22, 1,0, 1,2,8'h22, 8'h06);
    vecs[8]  = mk(0,0,0,     0,0,0,     0,1, 1,1,8'h11, 8'h06);
    vecs[9]  = mk(0,0,0,     0,0,0,     1,1, 1,2,8'h22, 8'h06);
    vecs[10] = mk(0,0,0,     0,0,0,     1,1, 1,1,8'h11, 8'h02);
    vecs[11] = mk(0,0,0,     0,0,0,     1,1, 0,0,0,     8'h00);

    #2;
    chk("rst_rdy0", req0Ready, 1);
    chk("rst_rdy1", req1Ready, 1);
    chk("rst_en", enableWrite, 0);
    chk("rst_reg", registerWrite, 0);
    chk("rst_data", dataIn, 0);
    chk("rst_mask", pendingMask, 0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v0, vecs[i].r0, vecs[i].d0,
           vecs[i].v1, vecs[i].r1, vecs[i].d1, 0);
      chk($sformatf("v%0d_rdy0", i), req0Ready, vecs[i].eRdy0);
      chk($sformatf("v%0d_rdy1", i), req1Ready, vecs[i].eRdy1);
      chk($sformatf("v%0d_en", i), enableWrite, vecs[i].eEn);
      chk($sformatf("v%0d_reg", i), registerWrite, vecs[i].eReg);
      chk($sformatf("v%0d_data", i), dataIn, vecs[i].eData);
      chk($sformatf("v%0d_mask", i), pendingMask, vecs[i].eMask);
    end

    sbOn = 1'b1;
    idle(1);

    // req1 first, req0 to the same register a cycle later
    push(5, 8'hAA); push(5, 8'hBB);
    step(0,0,0, 1,5,8'hAA, 0);
    step(1,5,8'hBB, 0,0,0, 0);
    chk("ord1_rdy0", req0Ready, 1);
    idle(5);
    drained("ord1_drain");

    // req1 waits behind r1 while req0 brings a younger r5
    push(1, 8'h11); push(5, 8'hAA); push(5, 8'hBB);
    step(1,1,8'h11, 1,5,8'hAA, 0);
    step(1,5,8'hBB, 0,0,0, 0);
    chk("ord2_rdy0", req0Ready, 1);
    chk("ord2_rdy1", req1Ready, 0);
    idle(5);
    drained("ord2_drain");

    // rrPtr now favours port 1; simultaneous same-reg accept
    push(5, 8'hAA); push(5, 8'hBB);
    step(1,5,8'hAA, 1,5,8'hBB, 0);
    step(0,0,0, 0,0,0, 0);
    chk("ord3_mask", pendingMask, 8'h20);
    idle(5);
    drained("ord3_drain");

    step(1,0,8'hFF, 0,0,0, 0);
    step(0,0,0, 0,0,0, 0);
    chk("r0_rdy0", req0Ready, 1);
    chk("r0_mask1", pendingMask, 0);
    step(0,0,0, 0,0,0, 0);
    chk("r0_en", enableWrite, 0);
    chk("r0_mask2", pendingMask, 0);
    idle(3);
    drained("r0_drain");

    push(1, 8'h11);
    step(1,1,8'h11, 0,0,0, 0);
    step(1,3,8'h33, 1,2,8'h22, 0);
    chk("fl_rdy0a", req0Ready, 1);
    chk("fl_rdy1a", req1Ready, 1);
    step(1,6,8'h66, 1,7,8'h77, 1);
    chk("fl_en", enableWrite, 1);
    chk("fl_reg", registerWrite, 1);
    chk("fl_mask", pendingMask, 8'h0E);
    step(0,0,0, 0,0,0, 0);
    chk("fl_rdy0b", req0Ready, 1);
    chk("fl_rdy1b", req1Ready, 1);
    chk("fl_mask2", pendingMask, 0);
    chk("fl_en2", enableWrite, 0);
    idle(5);
    drained("fl_drain");

    push(6, 8'h66);
    step(1,6,8'h66, 0,0,0, 0);
    step(1,7,8'h77, 1,5,8'h55, 0);
    step(0,0,0, 0,0,0, 0);
    chk("ar_en_pre", enableWrite, 1);
    #2;
    resetN = 1'b0;
    #1;
    chk("ar_en", enableWrite, 0);
    chk("ar_reg", registerWrite, 0);
    chk("ar_data", dataIn, 0);
    chk("ar_mask", pendingMask, 0);
    chk("ar_rdy0", req0Ready, 1);
    chk("ar_rdy1", req1Ready, 1);
    @(negedge clock);
    resetN = 1'b1;
    idle(6);
    chk("ar_mask_post", pendingMask, 0);
    drained("ar_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
